alu_64bit: RTL and testbench
============================

ALU_64BIT -- requirements
Module: alu_64bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk is the single clock, rst_n is the asynchronous active-low reset.
REQ-002 Ports SHALL be as follows (clock and reset first):
- clk  input  1  rising-edge clock for the condition-code register
- rst_n  input  1  asynchronous active-low reset
- X  input  64  operand A (two's complement)
- Y  input  64  operand B (two's complement)
- Control  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 XOR
- Result  output  64  operation result
- Overflow  output  1  combinational signed overflow of the current operation
- Overflow_flag  output  1  registered OF condition code
- Sign_flag  output  1  registered SF condition code
- Zero_flag  output  1  registered ZF condition code
REQ-003 The block SHALL have no parameters; width is fixed at 64 bits.

Function
REQ-004 Result and Overflow SHALL be purely combinational from X, Y and Control, with zero-cycle latency, and SHALL be unaffected by clk and rst_n.
REQ-005 Control=00: Result SHALL be X+Y mod 2^64; carry-out is discarded.
REQ-006 Control=01: Result SHALL be X-Y mod 2^64, computed as X + ~Y + 1 through the same 64-bit adder.
REQ-007 Control=10: Result SHALL be the bitwise X AND Y.
REQ-008 Control=11: Result SHALL be the bitwise X XOR Y.
REQ-009 For ADD, Overflow SHALL be 1 iff X[63]==Y[63] and Result[63]!=X[63].
REQ-010 For SUB, Overflow SHALL be 1 iff X[63]!=Y[63] and Result[63]!=X[63].
REQ-011 For AND and XOR, Overflow SHALL be 0.
REQ-012 On every rising clk edge with rst_n high, the condition codes SHALL load as follows: Overflow_flag<=Overflow, Sign_flag<=Result[63], Zero_flag<=(Result==0).
REQ-013 The condition codes SHALL hold their values between clock edges, so flags reflect the operands present at the most recent rising edge (one-cycle latency).
REQ-014 The condition codes SHALL be updated for all four operations; there is no enable.
REQ-015 The adder SHALL be a structural 64-bit ripple-carry chain built from 1-bit full adders; the logic operations SHALL be bitwise gate arrays, and a 4:1 select SHALL drive Result.
REQ-016 Unknown or X values on Control SHALL NOT be required to produce defined outputs; all four encodings are legal.

Reset
REQ-017 While rst_n is low, Overflow_flag, Sign_flag and Zero_flag SHALL be 0, asynchronously and immediately, regardless of clk.
REQ-018 Asserting rst_n mid-operation SHALL NOT affect Result or Overflow.
REQ-019 After rst_n deasserts, the first rising clk edge SHALL load the flags per REQ-012.

Verification
REQ-020 ADD X=2000, Y=60, then one clock edge -> Result=2060, Overflow=0, ZF=0, SF=0, OF=0.
REQ-021 ADD X=3, Y=-4, then one clock edge -> Result=0xFFFF_FFFF_FFFF_FFFF (-1), Overflow=0, SF=1, ZF=0.
REQ-022 SUB X=1000, Y=500 -> Result=500, flags 0; SUB X=Y=0xCCCC_CCCC_CCCC_CCCC -> Result=0, ZF=1, SF=0, OF=0; SUB X=10, Y=70 -> Result=-60, SF=1, ZF=0.
REQ-023 X=0xCCCC_CCCC_CCCC_CCCC, Y=0xAAAA_AAAA_AAAA_AAAA: AND -> Result=0x8888_8888_8888_8888, SF=1, Overflow=0; XOR -> Result=0x6666_6666_6666_6666, SF=0, ZF=0.
REQ-024 Overflow cases: ADD 0x7FFF_FFFF_FFFF_FFFF+1 -> Result=0x8000_0000_0000_0000, Overflow=1, then OF=1, SF=1 after the edge; SUB 0x8000_0000_0000_0000-1 -> Result=0x7FFF_FFFF_FFFF_FFFF, Overflow=1.
REQ-025 Reset: with flags non-zero, pulse rst_n low between clock edges -> all three flags 0 immediately while Result stays unchanged; flags reload on the next rising edge after release.

Source files
------------

// File: rtl/alu_64bit.sv
// -----------------------------------------------------------------------------
// alu_64bit_fa : 1-bit full adder, the cell of the ripple-carry chain.
//   a_i, b_i, c_i : addend bits and carry in
//   s_o, c_o      : sum bit and carry out
// -----------------------------------------------------------------------------
module alu_64bit_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// -----------------------------------------------------------------------------
// alu_64bit : 64-bit two's complement ALU with registered condition codes.
//   clk           : rising-edge clock for the condition-code register
//   rst_n         : asynchronous active-low reset of the condition codes
//   X, Y          : 64-bit operands
//   Control       : 00 ADD, 01 SUB, 10 AND, 11 XOR
//   Result        : combinational operation result
//   Overflow      : combinational signed overflow (ADD/SUB only)
//   Overflow_flag : registered OF
//   Sign_flag     : registered SF (Result[63])
//   Zero_flag     : registered ZF (Result == 0)
// -----------------------------------------------------------------------------
module alu_64bit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] X,
   input  logic [63:0] Y,
   input  logic [1:0]  Control,
   output logic [63:0] Result,
   output logic        Overflow,
   output logic        Overflow_flag,
   output logic        Sign_flag,
   output logic        Zero_flag
);
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   logic        sub;
   logic [63:0] b_eff;
   logic [63:0] sum;
   logic [63:0] and_res;
   logic [63:0] xor_res;
   logic        carry_unused;

   // Subtraction reuses the adder as X + ~Y + 1.
   assign sub   = (Control == OP_SUB);
   assign b_eff = sub ? ~Y : Y;

   // Each stage owns its carry-out; the next stage reaches back for it. Keeping
   // carries out of a shared vector avoids a false combinational loop on it.
   for (genvar i = 0; i < 64; i++) begin : g_rc
      logic ci;
      logic co;
      if (i == 0) begin : g_c0
         assign ci = sub;
      end else begin : g_cn
         assign ci = g_rc[i-1].co;
      end
      alu_64bit_fa u_fa (
         .a_i (X[i]),
         .b_i (b_eff[i]),
         .c_i (ci),
         .s_o (sum[i]),
         .c_o (co)
      );
   end

   // Final carry-out is discarded (results are mod 2^64).
   assign carry_unused = g_rc[63].co;

   assign and_res = X & Y;
   assign xor_res = X ^ Y;

   always_comb begin
      Result   = sum;
      Overflow = 1'b0;
      case (Control)
         OP_ADD: begin
            Result   = sum;
            Overflow = (X[63] == Y[63]) && (sum[63] != X[63]);
         end
         OP_SUB: begin
            Result   = sum;
            Overflow = (X[63] != Y[63]) && (sum[63] != X[63]);
         end
         OP_AND: Result = and_res;
         OP_XOR: Result = xor_res;
         default: begin
            Result   = sum;
            Overflow = 1'b0;
         end
      endcase
   end

   // Condition codes: load every edge, no enable.
   logic of_q, of_d;
   logic sf_q, sf_d;
   logic zf_q, zf_d;

   assign of_d = Overflow;
   assign sf_d = Result[63];
   assign zf_d = (Result == 64'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         of_q <= 1'b0;
         sf_q <= 1'b0;
         zf_q <= 1'b0;
      end else begin
         of_q <= of_d;
         sf_q <= sf_d;
         zf_q <= zf_d;
      end
   end

   assign Overflow_flag = of_q;
   assign Sign_flag     = sf_q;
   assign Zero_flag     = zf_q;
endmodule

// File: tb/tb_alu_64bit.sv
// -----------------------------------------------------------------------------
// tb_alu_64bit : directed-vector bench for alu_64bit. Checks combinational
// Result/Overflow right after operands change and the condition codes one
// rising edge later, plus asynchronous reset behaviour.
// -----------------------------------------------------------------------------
module tb_alu_64bit;
   logic        clk;
   logic        rst_n;
   logic [63:0] X;
   logic [63:0] Y;
   logic [1:0]  Control;
   logic [63:0] Result;
   logic        Overflow;
   logic        Overflow_flag;
   logic        Sign_flag;
   logic        Zero_flag;

   int n_tests = 0;
   int n_fail  = 0;

   alu_64bit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .X             (X),
      .Y             (Y),
      .Control       (Control),
      .Result        (Result),
      .Overflow      (Overflow),
      .Overflow_flag (Overflow_flag),
      .Sign_flag     (Sign_flag),
      .Zero_flag     (Zero_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply one operation, check combinational outputs, then clock once and
   // check the condition codes. Flags expected: OF=ov, SF=res[63], ZF=(res==0).
   task automatic run_vec(input string tag, input logic [1:0] ctrl,
                          input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] exp_res, input logic exp_ov);
      Control = ctrl;
      X       = x;
      Y       = y;
      #1;
      chk({tag, ".res"}, Result, exp_res);
      chk({tag, ".ov"},  {63'd0, Overflow}, {63'd0, exp_ov});
      @(posedge clk);
      #1;
      chk({tag, ".OF"}, {63'd0, Overflow_flag}, {63'd0, exp_ov});
      chk({tag, ".SF"}, {63'd0, Sign_flag},     {63'd0, exp_res[63]});
      chk({tag, ".ZF"}, {63'd0, Zero_flag},     {63'd0, exp_res == 64'd0});
   endtask

   initial begin
      rst_n   = 1'b0;
      Control = 2'b00;
      X       = 64'd0;
      Y       = 64'd0;
      #2;
      chk("rst.OF", {63'd0, Overflow_flag}, 64'd0);
      chk("rst.SF", {63'd0, Sign_flag},     64'd0);
      chk("rst.ZF", {63'd0, Zero_flag},     64'd0);
      // Result is zero here, yet ZF must stay 0 across an edge held in reset.
      @(posedge clk);
      #1;
      chk("rst_hold.ZF", {63'd0, Zero_flag}, 64'd0);
      chk("rst_hold.res", Result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_vec("add_2000_60", 2'b00, 64'd2000, 64'd60, 64'd2060, 1'b0);
      run_vec("add_3_m4",    2'b00, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      run_vec("sub_1000_500", 2'b01, 64'd1000, 64'd500, 64'd500, 1'b0);
      run_vec("sub_eq", 2'b01, 64'hCCCC_CCCC_CCCC_CCCC, 64'hCCCC_CCCC_CCCC_CCCC,
              64'd0, 1'b0);
      run_vec("sub_10_70", 2'b01, 64'd10, 64'd70, 64'hFFFF_FFFF_FFFF_FFC4, 1'b0);
      run_vec("and_ca", 2'b10, 64'hCCCC_CCCC_CCCC_CCCC, 64'hAAAA_AAAA_AAAA_AAAA,
              64'h8888_8888_8888_8888, 1'b0);
      run_vec("xor_ca", 2'b11, 64'hCCCC_CCCC_CCCC_CCCC, 64'hAAAA_AAAA_AAAA_AAAA,
              64'h6666_6666_6666_6666, 1'b0);
      run_vec("add_ovf", 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
              64'h8000_0000_0000_0000, 1'b1);
      run_vec("add_wrap", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0);
      run_vec("and_noovf", 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
      run_vec("xor_self", 2'b11, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
              64'd0, 1'b0);
      run_vec("sub_0_min", 2'b01, 64'd0, 64'h8000_0000_0000_0000,
              64'h8000_0000_0000_0000, 1'b1);
      run_vec("sub_ovf", 2'b01, 64'h8000_0000_0000_0000, 64'd1,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1);

      // Flags now OF=1, SF=0, ZF=0. Pulse reset between edges.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.OF",  {63'd0, Overflow_flag}, 64'd0);
      chk("arst.SF",  {63'd0, Sign_flag},     64'd0);
      chk("arst.ZF",  {63'd0, Zero_flag},     64'd0);
      chk("arst.res", Result, 64'h7FFF_FFFF_FFFF_FFFF);
      chk("arst.ov",  {63'd0, Overflow}, 64'd1);
      rst_n = 1'b1;
      #1;
      chk("arst_rel.OF", {63'd0, Overflow_flag}, 64'd0);
      @(posedge clk);
      #1;
      chk("reload.OF", {63'd0, Overflow_flag}, 64'd1);
      chk("reload.SF", {63'd0, Sign_flag},     64'd0);
      chk("reload.ZF", {63'd0, Zero_flag},     64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
